crc_frame_receiver: RTL and testbench
=====================================

CRC_FRAME_RECEIVER -- requirements
Module: crc_frame_receiver

Interface
REQ-001 Parameter DATA_W, default 128: number of payload bits per frame.
REQ-002 Parameter CRC_W, default 32: number of trailing CRC bits per frame, and the CRC register width.
REQ-003 Parameter POLY, default 32'h04C11DB7: generator polynomial, implicit x^CRC_W term omitted.
REQ-004 Parameter INIT_VAL, default 32'hFFFFFFFF: CRC register value at the start of each frame.
REQ-005 Parameter FINAL_XOR, default 32'h00000000: value XORed onto the CRC register to form crc_calc.
REQ-006 clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 rst, input, 1: asynchronous, active-high reset.
REQ-008 serial, input, 1: frame bit, valid only when enable=1.
REQ-009 enable, input, 1: qualifier; one bit is accepted per rising edge with enable=1.
REQ-010 abort, input, 1: synchronous frame discard.
REQ-011 data_out, output, DATA_W: received payload; first received bit is the MSB.
REQ-012 crc_rx, output, CRC_W: received CRC field; first received CRC bit is the MSB.
REQ-013 crc_calc, output, CRC_W: locally computed CRC over the payload, after FINAL_XOR.
REQ-014 crc_ok, output, 1: crc_calc equals crc_rx; meaningful while valid=1.
REQ-015 valid, output, 1: one-cycle pulse marking frame completion.
REQ-016 busy, output, 1: high while a frame is partially received.

Function
REQ-017 States: IDLE, DATA, CRC; a bit counter of width clog2(DATA_W+CRC_W) counts accepted bits.
REQ-018 Transitions: IDLE→DATA on the first enable=1 edge; DATA→CRC after the DATA_W-th accepted bit; CRC→IDLE on the CRC_W-th CRC bit.
REQ-019 Each accepted DATA bit: shift into the payload register LSB-side; fb = crc[CRC_W-1]^serial; crc = {crc[CRC_W-2:0],0} ^ (fb ? POLY : 0).
REQ-020 CRC state: accepted bits shift into the crc_rx register LSB-side; the CRC register is frozen.
REQ-021 The edge sampling the last CRC bit updates data_out, crc_rx, crc_calc and crc_ok and sets valid=1 for exactly one cycle.
REQ-022 The same edge reloads the CRC register with INIT_VAL.
REQ-023 data_out, crc_rx, crc_calc and crc_ok hold their values until the next frame completes.
REQ-024 Latency: zero cycles; results are visible in the cycle after the last enable=1 edge.
REQ-025 enable=0 pauses the receiver: no state, counter or register change; gaps of any length are allowed.
REQ-026 A new frame's first bit may arrive on the edge immediately after the completing edge (back-to-back frames).
REQ-027 The first bit of a frame that begins in IDLE uses INIT_VAL as the CRC seed.
REQ-028 abort=1 at an edge forces IDLE, clears the counter, reloads INIT_VAL, holds busy=0 and valid=0, and ignores serial/enable at that edge.
REQ-029 abort has priority over enable.
REQ-030 abort does not alter data_out, crc_rx, crc_calc or crc_ok.
REQ-031 busy=1 iff the state is DATA or CRC.

Reset
REQ-032 rst=1 immediately forces IDLE, counter=0, CRC register=INIT_VAL.
REQ-033 rst=1 immediately forces data_out=0, crc_rx=0, crc_calc=0, crc_ok=0, valid=0, busy=0.
REQ-034 Reset mid-frame discards the partial frame; the next enable=1 starts a new frame.

Verification (DATA_W=8, CRC_W=8, POLY=8'h07, INIT_VAL=8'h00, FINAL_XOR=8'h00 unless noted)
REQ-035 Serial 8'h01 then 8'h07, contiguous enable → valid pulses once at the 16th edge; data_out=8'h01, crc_calc=8'h07, crc_ok=1.
REQ-036 Serial 8'h01 then 8'h06 → crc_ok=0, crc_rx=8'h06, crc_calc=8'h07.
REQ-037 Same frame as REQ-035 with random enable gaps of 0–5 cycles → identical results; valid only on the 16th accepted bit; busy high throughout the gaps.
REQ-038 Abort after 5 bits, then a full 8'h00/8'h00 frame → no valid pulse for the aborted frame; the new frame gives crc_ok=1, data_out=8'h00.
REQ-039 rst asserted mid-frame (between clock edges) → outputs zero immediately; a following 8'h01/8'h07 frame passes.
REQ-040 Default parameters, driven by parallel_to_serial with a 160-bit word (payload + CRC produced by crc_static with matching parameters) → crc_ok=1, data_out equals payload; back-to-back repeat also passes.

Source files
------------

// File: rtl/crc_frame_receiver.sv
// crc_frame_receiver: serial frame receiver that checks a trailing CRC field against a locally computed CRC
//   clk, rst (async, active-high); serial/enable bit input; abort discards the current frame
//   data_out/crc_rx/crc_calc/crc_ok hold results of the last complete frame; valid pulses on completion; busy while mid-frame
module crc_frame_receiver #(
  parameter int DATA_W = 128,
  parameter int CRC_W = 32,
  parameter logic [CRC_W-1:0] POLY = 32'h04C11DB7,
  parameter logic [CRC_W-1:0] INIT_VAL = 32'hFFFFFFFF,
  parameter logic [CRC_W-1:0] FINAL_XOR = 32'h00000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial,
  input  logic              enable,
  input  logic              abort,
  output logic [DATA_W-1:0] data_out,
  output logic [CRC_W-1:0]  crc_rx,
  output logic [CRC_W-1:0]  crc_calc,
  output logic              crc_ok,
  output logic              valid,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W + CRC_W);
  localparam logic [CW-1:0] LAST_D = CW'(DATA_W - 1);
  localparam logic [CW-1:0] LAST_F = CW'(DATA_W + CRC_W - 1);
  typedef enum logic [1:0] {IDLE, DATA, CRC} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [CRC_W-1:0] crc, crc_n, rx_sh, rx_fin, crc_fin;
  logic [DATA_W-1:0] data_sh;
  logic acc_data, done, fb;
  assign fb = crc[CRC_W-1] ^ serial;
  assign crc_n = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  assign rx_fin = {rx_sh[CRC_W-2:0], serial};
  assign crc_fin = crc ^ FINAL_XOR;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // IDLE and DATA both accept payload bits, so the first bit of a frame is handled like any other.
  always_comb begin
    state_n = state;
    acc_data = 1'b0;
    done = 1'b0;
    if (abort) state_n = IDLE;
    else if (enable) begin
      if (state == CRC) begin
        done = cnt == LAST_F;
        state_n = done ? IDLE : CRC;
      end else begin
        acc_data = 1'b1;
        state_n = cnt == LAST_D ? CRC : DATA;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      crc <= INIT_VAL;
      data_sh <= '0;
      rx_sh <= '0;
      data_out <= '0;
      crc_rx <= '0;
      crc_calc <= '0;
      crc_ok <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= done;
      if (abort) begin
        cnt <= '0;
        crc <= INIT_VAL;
      end else if (enable) begin
        cnt <= done ? '0 : cnt + 1'b1;
        if (acc_data) begin
          data_sh <= {data_sh[DATA_W-2:0], serial};
          crc <= crc_n;
        end else rx_sh <= rx_fin;
        if (done) begin
          data_out <= data_sh;
          crc_rx <= rx_fin;
          crc_calc <= crc_fin;
          crc_ok <= crc_fin == rx_fin;
          crc <= INIT_VAL;
        end
      end
    end
endmodule

// File: tb/tb_crc_frame_receiver.sv
// tb_crc_frame_receiver: self-checking bench for crc_frame_receiver (8/8 CRC-8 instance plus default CRC-32 instance)
module tb_crc_frame_receiver;
  logic clk = 1'b0, rst = 1'b1;
  logic serial = 1'b0, enable = 1'b0, abort = 1'b0;
  logic serial_b = 1'b0, enable_b = 1'b0;
  logic [7:0] d_out, c_rx, c_calc;
  logic ok, valid, busy;
  logic [127:0] data_b;
  logic [31:0] rx_b, calc_b;
  logic ok_b, valid_b, busy_b;
  int vectors = 0, miscompares = 0;
  int vcnt_s = 0, vcnt_b = 0, exp_vs = 0, exp_vb = 0;

  always #5 clk = ~clk;

  crc_frame_receiver #(.DATA_W(8), .CRC_W(8), .POLY(8'h07), .INIT_VAL(8'h00), .FINAL_XOR(8'h00)) dut_s (
    .clk(clk), .rst(rst), .serial(serial), .enable(enable), .abort(abort),
    .data_out(d_out), .crc_rx(c_rx), .crc_calc(c_calc), .crc_ok(ok), .valid(valid), .busy(busy));

  crc_frame_receiver dut_b (
    .clk(clk), .rst(rst), .serial(serial_b), .enable(enable_b), .abort(1'b0),
    .data_out(data_b), .crc_rx(rx_b), .crc_calc(calc_b), .crc_ok(ok_b), .valid(valid_b), .busy(busy_b));

  // valid lasts one full clock cycle, so one sample per falling edge counts each pulse once
  always @(negedge clk) begin
    if (valid) vcnt_s++;
    if (valid_b) vcnt_b++;
  end

  task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // CRC as the remainder of polynomial long division: the first w message bits are
  // pre-inverted by the seed, the message is extended by w zero bits, and the result gets fx.
  function automatic logic [31:0] crc_ref(input logic [127:0] d, input int n, input int w,
                                          input logic [31:0] poly, input logic [31:0] init, input logic [31:0] fx);
    logic [159:0] m = '0;
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) m[w+i] = d[i];
    for (int j = 0; j < w; j++) m[n+w-1-j] ^= init[w-1-j];
    for (int i = n + w - 1; i >= w; i--)
      if (m[i]) begin
        for (int j = 0; j < w; j++) m[i-1-j] ^= poly[w-1-j];
        m[i] = 1'b0;
      end
    for (int j = 0; j < w; j++) r[j] = m[j];
    return r ^ fx;
  endfunction

  // Sends one 16-bit frame MSB first; leaves enable high so a following call is back-to-back.
  task automatic send_small(input logic [7:0] d, input logic [7:0] c, input int maxgap);
    logic [15:0] f = {d, c};
    for (int i = 15; i >= 0; i--) begin
      int g = maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0;
      repeat (g) begin
        @(negedge clk); enable = 1'b0; serial = 1'($urandom);
        @(posedge clk); #1;
        if (i < 15) chk("busy_gap", busy, 1);
      end
      @(negedge clk); serial = f[i]; enable = 1'b1;
      @(posedge clk); #1;
      if (i == 1) begin
        chk("valid_early", valid, 0);
        chk("busy_mid", busy, 1);
      end
    end
    chk("valid_last", valid, 1);
    chk("busy_done", busy, 0);
    exp_vs++;
  endtask

  task automatic finish_small();
    @(negedge clk); enable = 1'b0;
    @(posedge clk); #1;
    chk("valid_drop", valid, 0);
    chk("valid_count", vcnt_s, exp_vs);
  endtask

  task automatic send_big(input logic [159:0] word);
    for (int i = 159; i >= 0; i--) begin
      @(negedge clk); serial_b = word[i]; enable_b = 1'b1;
      @(posedge clk); #1;
    end
    chk("big_valid", valid_b, 1);
    exp_vb++;
  endtask

  typedef struct {
    logic [7:0] d;
    logic [7:0] c;
    logic [7:0] calc;
    logic ok;
  } vec_t;

  initial begin
    vec_t tbl[6];
    logic [127:0] pay;
    logic [31:0] crc32;
    tbl[0] = '{8'h01, 8'h07, 8'h07, 1'b1};
    tbl[1] = '{8'h01, 8'h06, 8'h07, 1'b0};
    tbl[2] = '{8'h00, 8'h00, 8'h00, 1'b1};
    tbl[3] = '{8'h80, 8'h89, 8'h89, 1'b1};
    tbl[4] = '{8'hFF, 8'hF3, 8'hF3, 1'b1};
    tbl[5] = '{8'hFF, 8'h00, 8'hF3, 1'b0};
    #12;
    chk("rst_data", d_out, 0);
    chk("rst_calc", c_calc, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_big_data", data_b, 0);
    @(negedge clk); rst = 1'b0;
    foreach (tbl[k]) begin
      send_small(tbl[k].d, tbl[k].c, 0);
      chk("tbl_data", d_out, tbl[k].d);
      chk("tbl_rx", c_rx, tbl[k].c);
      chk("tbl_calc", c_calc, tbl[k].calc);
      chk("tbl_ok", ok, tbl[k].ok);
      finish_small();
    end
    // same frame with random enable gaps
    send_small(8'h01, 8'h07, 5);
    chk("gap_data", d_out, 8'h01);
    chk("gap_calc", c_calc, 8'h07);
    chk("gap_ok", ok, 1);
    finish_small();
    // back-to-back frames
    send_small(8'h80, 8'h89, 0);
    chk("b2b1_calc", c_calc, 8'h89);
    send_small(8'h01, 8'h07, 0);
    chk("b2b2_data", d_out, 8'h01);
    chk("b2b2_ok", ok, 1);
    finish_small();
    // abort after 5 bits; results of the previous frame must survive
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); serial = 1'b1; enable = 1'b1;
    end
    @(negedge clk); abort = 1'b1; serial = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_data", d_out, 8'h01);
    chk("abort_calc", c_calc, 8'h07);
    chk("abort_ok", ok, 1);
    @(negedge clk); abort = 1'b0; enable = 1'b0;
    send_small(8'h00, 8'h00, 0);
    chk("post_abort_data", d_out, 8'h00);
    chk("post_abort_ok", ok, 1);
    finish_small();
    // async reset in the middle of a frame
    send_small(8'hFF, 8'hF3, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); serial = 1'b1; enable = 1'b1;
    end
    @(negedge clk); enable = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_data", d_out, 0);
    chk("arst_rx", c_rx, 0);
    chk("arst_calc", c_calc, 0);
    chk("arst_ok", ok, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk); rst = 1'b0;
    send_small(8'h01, 8'h07, 0);
    chk("post_rst_data", d_out, 8'h01);
    chk("post_rst_ok", ok, 1);
    finish_small();
    // randomized frames against the division model
    for (int k = 0; k < 25; k++) begin
      logic [7:0] d = 8'($urandom);
      logic [7:0] r = crc_ref({120'h0, d}, 8, 8, 32'h07, 32'h0, 32'h0);
      logic [7:0] c = ($urandom % 2) ? r : 8'($urandom);
      send_small(d, c, 3);
      chk("rnd_data", d_out, d);
      chk("rnd_rx", c_rx, c);
      chk("rnd_calc", c_calc, r);
      chk("rnd_ok", ok, c == r);
      if (k % 5 == 4) finish_small();
    end
    finish_small();
    // default CRC-32 instance, two back-to-back frames plus a corrupted one
    for (int k = 0; k < 3; k++) begin
      pay = {$urandom, $urandom, $urandom, $urandom};
      crc32 = crc_ref(pay, 128, 32, 32'h04C11DB7, 32'hFFFFFFFF, 32'h0);
      send_big({pay, (k == 2) ? crc32 ^ 32'h1 : crc32});
      chk("big_data", data_b, pay);
      chk("big_calc", calc_b, crc32);
      chk("big_ok", ok_b, k != 2);
    end
    @(negedge clk); enable_b = 1'b0;
    @(posedge clk); #1;
    chk("big_valid_drop", valid_b, 0);
    chk("big_valid_count", vcnt_b, exp_vb);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
